// File: rtl/ghash_block_sequencer.sv
// ghash_block_sequencer
//
// Front-end controller for ghash_core. It accepts 128-bit AAD and ciphertext
// blocks over a valid/ready handshake and zero-pads partial blocks. Each block
// is chained through the core, with the previous core result fed back as
// x_prev. The len(A)||len(C) block is appended last, and the final GHASH is
// presented with a one-cycle valid pulse.
//
// Optional feature macro: GHASH_SEQ_ORDER_CHECK_EN
//   defined   -> o_error is set by an AAD block accepted after a ciphertext
//                block of the same message. It is sticky until i_start or
//                i_reset.
//   undefined -> o_error is tied to 0.
//
// Parameters
//   NB_DATA       block width (128 only)
//   CORE_LATENCY  cycles from o_core_valid high to i_core_data_y valid (1..15)
//
// Ports
//   i_clock, i_reset          clock, asynchronous active-high reset
//   i_start, i_start_empty    begin a message (optionally with no data blocks)
//   i_data, i_valid, i_is_aad,
//   i_nbytes, i_last          input block and its attributes
//   o_ready                   block accepted on i_valid & o_ready
//   o_core_data_x             masked block / length block to the core
//   o_core_data_x_prev        running accumulator to the core
//   o_core_valid              one-cycle core strobe
//   i_core_data_y             core result
//   o_ghash, o_ghash_valid    final GHASH and its one-cycle pulse
//   o_busy                    high in every state except IDLE
//   o_error                   sticky ordering error
module ghash_block_sequencer #(
  parameter int NB_DATA      = 128,
  parameter int CORE_LATENCY = 1
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic               i_start_empty,
  input  logic [NB_DATA-1:0] i_data,
  input  logic               i_valid,
  input  logic               i_is_aad,
  input  logic [4:0]         i_nbytes,
  input  logic               i_last,
  output logic               o_ready,
  output logic [NB_DATA-1:0] o_core_data_x,
  output logic [NB_DATA-1:0] o_core_data_x_prev,
  output logic               o_core_valid,
  input  logic [NB_DATA-1:0] i_core_data_y,
  output logic [NB_DATA-1:0] o_ghash,
  output logic               o_ghash_valid,
  output logic               o_busy,
  output logic               o_error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCEPT,
    S_WAIT,
    S_LEN,
    S_WAIT_LEN
  } state_t;

  localparam logic [3:0] LAT = 4'(CORE_LATENCY);

  state_t             state;
  logic [NB_DATA-1:0] acc;
  logic [63:0]        len_a;
  logic [63:0]        len_c;
  logic [3:0]         wait_cnt;
  logic               last_q;

  logic [4:0]         nbytes_eff;
  logic [NB_DATA-1:0] byte_mask;
  logic [63:0]        bit_count;

  // Byte counts of 0 or above 16 mean a full block.
  assign nbytes_eff = (i_nbytes == 5'd0 || i_nbytes > 5'd16) ? 5'd16 : i_nbytes;
  assign bit_count  = {56'd0, nbytes_eff, 3'b000};

  // Byte 0 sits in the top byte lane. Lanes at or beyond nbytes_eff are cleared.
  always_comb begin
    // NOTE: default assignment first so no path through this block infers a latch.
    byte_mask = '0;
    for (int b = 0; b < 16; b++) begin
      if (5'(b) < nbytes_eff) byte_mask[NB_DATA-1-8*b -: 8] = 8'hff;
    end
  end

  assign o_ready = (state == S_ACCEPT);
  assign o_busy  = (state != S_IDLE);

`ifdef GHASH_SEQ_ORDER_CHECK_EN
  logic seen_ct;
`else
  assign o_error = 1'b0;
`endif

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state              <= S_IDLE;
      acc                <= '0;
      len_a              <= '0;
      len_c              <= '0;
      wait_cnt           <= '0;
      last_q             <= 1'b0;
      o_core_data_x      <= '0;
      o_core_data_x_prev <= '0;
      o_core_valid       <= 1'b0;
      o_ghash            <= '0;
      o_ghash_valid      <= 1'b0;
`ifdef GHASH_SEQ_ORDER_CHECK_EN
      seen_ct            <= 1'b0;
      o_error            <= 1'b0;
`endif
    end else begin
      // Both strobes are single-cycle pulses.
      o_core_valid  <= 1'b0;
      o_ghash_valid <= 1'b0;

      if (i_start) begin
        // Start takes priority everywhere. It also aborts a message in flight,
        // and any core result still pending is simply never sampled.
        acc      <= '0;
        len_a    <= '0;
        len_c    <= '0;
        wait_cnt <= '0;
        last_q   <= 1'b0;
        state    <= i_start_empty ? S_LEN : S_ACCEPT;
`ifdef GHASH_SEQ_ORDER_CHECK_EN
        seen_ct  <= 1'b0;
        o_error  <= 1'b0;
`endif
      end else begin
        case (state)
          S_IDLE: ;

          S_ACCEPT: begin
            if (i_valid) begin
              o_core_data_x      <= i_data & byte_mask;
              o_core_data_x_prev <= acc;
              o_core_valid       <= 1'b1;
              if (i_is_aad) len_a <= len_a + bit_count;
              else          len_c <= len_c + bit_count;
              last_q   <= i_last;
              wait_cnt <= LAT;
              state    <= S_WAIT;
`ifdef GHASH_SEQ_ORDER_CHECK_EN
              if (!i_is_aad)    seen_ct <= 1'b1;
              else if (seen_ct) o_error <= 1'b1;
`endif
            end
          end

          S_WAIT: begin
            if (wait_cnt == 4'd0) begin
              acc   <= i_core_data_y;
              state <= last_q ? S_LEN : S_ACCEPT;
            end else begin
              wait_cnt <= wait_cnt - 4'd1;
            end
          end

          S_LEN: begin
            o_core_data_x      <= {len_a, len_c};
            o_core_data_x_prev <= acc;
            o_core_valid       <= 1'b1;
            wait_cnt           <= LAT;
            state              <= S_WAIT_LEN;
          end

          S_WAIT_LEN: begin
            if (wait_cnt == 4'd0) begin
              o_ghash       <= i_core_data_y;
              o_ghash_valid <= 1'b1;
              state         <= S_IDLE;
            end else begin
              wait_cnt <= wait_cnt - 4'd1;
            end
          end

          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ghash_block_sequencer.sv
// Testbench for ghash_block_sequencer.
// Two instances are used: instance 0 has CORE_LATENCY=1 and instance 1 has
// CORE_LATENCY=4. Each instance is paired with a behavioural ghash_core that
// computes y = (x ^ x_prev) * H after the instance's latency. A message-level
// reference model predicts every core strobe, the final GHASH and the error
// flag. A single compare process checks these predictions on every cycle.
module tb_ghash_block_sequencer;

  localparam logic [127:0] H    = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [127:0] C1   = 128'h0388dace60b6a392f328c2b971b2fe78;
  localparam logic [127:0] G_C1 = 128'hf38cbb1ad69223dcc3457ae5b6b0f885;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cycle = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // GF(2^128) multiply as defined for GCM (bit 0 of a block is its MSB).
  function automatic logic [127:0] gf_mult(input logic [127:0] x, input logic [127:0] y);
    logic [127:0] z;
    logic [127:0] v;
    z = '0;
    v = y;
    for (int i = 0; i < 128; i++) begin
      if (x[127-i]) z ^= v;
      if (v[0]) v = (v >> 1) ^ {8'he1, 120'd0};
      else      v = v >> 1;
    end
    return z;
  endfunction

  function automatic int eff_bytes(input int n);
    return (n == 0 || n > 16) ? 16 : n;
  endfunction

  function automatic logic [127:0] mask_bytes(input logic [127:0] d, input int n);
    logic [127:0] r;
    r = d;
    for (int b = 0; b < 16; b++) if (b >= eff_bytes(n)) r[127-8*b -: 8] = 8'h00;
    return r;
  endfunction

  function automatic int lat(input int k);
    return (k == 0) ? 1 : 4;
  endfunction

  // DUT-side signals, one slot per instance.
  logic         start [2];
  logic         start_empty [2];
  logic [127:0] data [2];
  logic         valid [2];
  logic         is_aad [2];
  logic [4:0]   nbytes [2];
  logic         last [2];
  logic         ready [2];
  logic [127:0] cx [2];
  logic [127:0] cxp [2];
  logic         cvalid [2];
  logic [127:0] cy [2];
  logic [127:0] ghash [2];
  logic         gvalid [2];
  logic         busy [2];
  logic         err [2];

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int L = (g == 0) ? 1 : 4;
    logic [127:0] pipe [L];

    always @(posedge clk) begin
      pipe[0] <= gf_mult(cx[g] ^ cxp[g], H);
      for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end
    assign cy[g] = pipe[L-1];

    ghash_block_sequencer #(.NB_DATA(128), .CORE_LATENCY(L)) dut (
      .i_clock           (clk),
      .i_reset           (rst),
      .i_start           (start[g]),
      .i_start_empty     (start_empty[g]),
      .i_data            (data[g]),
      .i_valid           (valid[g]),
      .i_is_aad          (is_aad[g]),
      .i_nbytes          (nbytes[g]),
      .i_last            (last[g]),
      .o_ready           (ready[g]),
      .o_core_data_x     (cx[g]),
      .o_core_data_x_prev(cxp[g]),
      .o_core_valid      (cvalid[g]),
      .i_core_data_y     (cy[g]),
      .o_ghash           (ghash[g]),
      .o_ghash_valid     (gvalid[g]),
      .o_busy            (busy[g]),
      .o_error           (err[g])
    );
  end

  // Reference model state (message level).
  logic [127:0] q_x [$];
  logic [127:0] q_xp [$];
  logic [127:0] q_g [$];
  logic [127:0] m_acc;
  logic [63:0]  m_la;
  logic [63:0]  m_lc;
  logic [127:0] m_last_g;
  bit           m_seen_ct;
  bit           exp_err [2];
  int           last_cv [2];

  // Compare process: checks every core strobe, GHASH pulse and the error flag.
  always @(negedge clk) begin
    cycle++;
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        if (cvalid[k]) begin
          check("core_valid_expected", 128'(q_x.size() > 0), 128'd1);
          if (q_x.size() > 0) begin
            check("core_x", cx[k], q_x.pop_front());
            check("core_x_prev", cxp[k], q_xp.pop_front());
          end
          last_cv[k] = cycle;
        end
        if (gvalid[k]) begin
          check("ghash_valid_expected", 128'(q_g.size() > 0), 128'd1);
          if (q_g.size() > 0) check("ghash", ghash[k], q_g.pop_front());
          check("ghash_latency", 128'(cycle - last_cv[k]), 128'(lat(k) + 1));
        end
        check("error_flag", 128'(err[k]), 128'(exp_err[k]));
      end
    end
  end

  task automatic push_len();
    q_x.push_back({m_la, m_lc});
    q_xp.push_back(m_acc);
    m_last_g = gf_mult({m_la, m_lc} ^ m_acc, H);
    q_g.push_back(m_last_g);
  endtask

  task automatic do_start(input int k, input bit empty);
    @(negedge clk);
    start[k] = 1'b1;
    start_empty[k] = empty;
    @(posedge clk);
    #1;
    start[k] = 1'b0;
    start_empty[k] = 1'b0;
    m_acc = '0;
    m_la = '0;
    m_lc = '0;
    m_seen_ct = 1'b0;
    exp_err[k] = 1'b0;
    if (empty) push_len();
  endtask

  task automatic send(input int k, input logic [127:0] d, input int n, input bit aad,
                      input bit lst, input bit gap_check);
    int t;
    int gap;
    logic [127:0] m;
    @(negedge clk);
    valid[k] = 1'b1;
    data[k] = d;
    nbytes[k] = 5'(n);
    is_aad[k] = aad;
    last[k] = lst;
    t = 0;
    while (!ready[k] && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("ready_within_bound", 128'(ready[k]), 128'd1);
    @(posedge clk);
    #1;
    valid[k] = 1'b0;
    last[k] = 1'b0;
    m = mask_bytes(d, n);
    q_x.push_back(m);
    q_xp.push_back(m_acc);
    m_acc = gf_mult(m ^ m_acc, H);
    if (aad) m_la = m_la + 64'(8 * eff_bytes(n));
    else     m_lc = m_lc + 64'(8 * eff_bytes(n));
`ifdef GHASH_SEQ_ORDER_CHECK_EN
    if (aad && m_seen_ct) exp_err[k] = 1'b1;
`endif
    if (!aad) m_seen_ct = 1'b1;
    if (lst) push_len();
    if (gap_check && !lst) begin
      gap = 0;
      @(negedge clk);
      while (!ready[k] && gap < 100) begin
        gap++;
        @(negedge clk);
      end
      check("ready_gap", 128'(gap), 128'(lat(k) + 1));
    end
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while ((q_x.size() != 0 || q_g.size() != 0) && t < 300) begin
      @(negedge clk);
      t++;
    end
    check("result_within_bound", 128'(q_x.size() + q_g.size()), 128'd0);
    @(negedge clk);
  endtask

  task automatic check_all_zero(input int k, input string tag);
    check({tag, "_ready"}, 128'(ready[k]), 128'd0);
    check({tag, "_core_x"}, cx[k], 128'd0);
    check({tag, "_core_x_prev"}, cxp[k], 128'd0);
    check({tag, "_core_valid"}, 128'(cvalid[k]), 128'd0);
    check({tag, "_ghash"}, ghash[k], 128'd0);
    check({tag, "_ghash_valid"}, 128'(gvalid[k]), 128'd0);
    check({tag, "_busy"}, 128'(busy[k]), 128'd0);
    check({tag, "_error"}, 128'(err[k]), 128'd0);
  endtask

  logic [127:0] blk [3];
  logic [127:0] g_lat1;
  logic [127:0] ones;

  initial begin
    for (int k = 0; k < 2; k++) begin
      start[k] = 0; start_empty[k] = 0; data[k] = '0; valid[k] = 0;
      is_aad[k] = 0; nbytes[k] = '0; last[k] = 0; exp_err[k] = 0; last_cv[k] = 0;
    end
    m_acc = '0; m_la = '0; m_lc = '0; m_seen_ct = 0; m_last_g = '0;
    rst = 1'b1;
    #12;
    for (int k = 0; k < 2; k++) check_all_zero(k, "reset");
    @(negedge clk);
    rst = 1'b0;

    // Pin the reference model with hand-known values.
    check("pin_gf_mult", gf_mult(C1, H), 128'h5e2ec746917062882c85b0685353deb7);
    check("pin_ghash_c1", gf_mult({64'd0, 64'h80} ^ gf_mult(C1, H), H), G_C1);
    ones = '1;
    check("pin_mask4", mask_bytes(ones, 4), {32'hffffffff, 96'd0});
    check("pin_mask0", mask_bytes(ones, 0), ones);

    // Empty message.
    do_start(0, 1'b1);
    wait_done();
    check("empty_ghash", ghash[0], 128'd0);

    // One full ciphertext block.
    do_start(0, 1'b0);
    send(0, C1, 16, 1'b0, 1'b1, 1'b1);
    wait_done();
    check("c1_ghash", ghash[0], G_C1);
    check("c1_len_block", cx[0], {64'd0, 64'h80});

    // Partial AAD block.
    do_start(0, 1'b0);
    send(0, ones, 4, 1'b1, 1'b1, 1'b1);
    wait_done();
    check("aad4_len_block", cx[0], {64'h20, 64'd0});

    // Latency sweep: same three-block message on both instances.
    for (int i = 0; i < 3; i++) blk[i] = {$urandom, $urandom, $urandom, $urandom};
    do_start(0, 1'b0);
    for (int i = 0; i < 3; i++) send(0, blk[i], 16, i == 0, i == 2, 1'b1);
    wait_done();
    g_lat1 = m_last_g;
    do_start(1, 1'b0);
    for (int i = 0; i < 3; i++) send(1, blk[i], 16, i == 0, i == 2, 1'b1);
    wait_done();
    check("lat4_matches_lat1", ghash[1], g_lat1);

    // Abort during WAIT of block 2, then a fresh one-block message.
    do_start(0, 1'b0);
    send(0, blk[0], 16, 1'b1, 1'b0, 1'b1);
    send(0, blk[1], 16, 1'b0, 1'b0, 1'b0);
    do_start(0, 1'b0);
    send(0, C1, 16, 1'b0, 1'b1, 1'b1);
    wait_done();
    check("after_abort_ghash", ghash[0], G_C1);

    // Asynchronous reset in WAIT_LEN: no pulse, everything back to zero.
    for (int k = 0; k < 2; k++) begin
      int t;
      do_start(k, 1'b0);
      send(k, C1, 16, 1'b0, 1'b1, 1'b1);
      t = 0;
      while (q_x.size() != 0 && t < 100) begin
        @(negedge clk);
        t++;
      end
      check("len_strobe_within_bound", 128'(q_x.size()), 128'd0);
      #2;
      rst = 1'b1;
      #1;
      check_all_zero(k, "async_reset");
      q_g.delete();
      exp_err[k] = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (8) @(negedge clk);
      check("no_pulse_after_reset", ghash[k], 128'd0);
    end

    // Ordering: ciphertext then AAD.
    do_start(0, 1'b0);
    send(0, blk[0], 16, 1'b0, 1'b0, 1'b1);
    send(0, blk[1], 8, 1'b1, 1'b1, 1'b1);
    wait_done();
    repeat (3) @(negedge clk);
`ifdef GHASH_SEQ_ORDER_CHECK_EN
    check("order_error_held", 128'(err[0]), 128'd1);
`else
    check("order_error_disabled", 128'(err[0]), 128'd0);
`endif
    do_start(0, 1'b1);
    check("order_error_cleared", 128'(err[0]), 128'd0);
    wait_done();

    // Randomized messages on either instance.
    for (int m = 0; m < 24; m++) begin
      int k;
      int nblk;
      int naad;
      bit mix;
      k = int'($urandom_range(0, 1));
      nblk = int'($urandom_range(0, 4));
      naad = int'($urandom_range(0, 4));
      mix = ($urandom_range(0, 3) == 0);
      do_start(k, nblk == 0);
      for (int i = 0; i < nblk; i++) begin
        bit aad;
        aad = mix ? bit'($urandom_range(0, 1)) : (i < naad);
        send(k, {$urandom, $urandom, $urandom, $urandom}, int'($urandom_range(0, 31)),
             aad, i == nblk - 1, bit'($urandom_range(0, 1)));
      end
      wait_done();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ghash_block_sequencer.md
# ghash_block_sequencer

Front-end controller for `ghash_core`: accepts a stream of 128-bit AAD and ciphertext blocks over a valid/ready handshake and zero-pads partial final blocks. It chains each block through the core, feeding the core's previous result back as `i_data_x_prev`, then appends the `len(A)||len(C)` block. It emits the final GHASH value with a one-cycle valid pulse. It sits directly upstream of `ghash_core` and drives its inputs, and it also consumes the core's `o_data_y`.

## Interface
- `NB_DATA`, 128, block width; only 128 is supported.
- `CORE_LATENCY`, 1, cycles from `o_core_valid` high to `i_core_data_y` being valid; range 1..15.
- `i_clock`  in  1  single clock; all logic is posedge.
- `i_reset`  in  1  asynchronous, active-high reset.
- `i_start`  in  1  pulse: begin a new message; clears the accumulator and both length counters.
- `i_start_empty`  in  1  qualifies `i_start`: the message has no data blocks and goes straight to the length block.
- `i_data`  in  NB_DATA  input block, byte 0 at [127:120].
- `i_valid`  in  1  input block valid.
- `i_is_aad`  in  1  1 = AAD block, 0 = ciphertext block.
- `i_nbytes`  in  5  valid bytes in the block, 1..16; values 0 and >16 are treated as 16.
- `i_last`  in  1  last data block of the message.
- `o_ready`  out  1  block accepted on `i_valid & o_ready`.
- `o_core_data_x`  out  NB_DATA  masked block to `ghash_core.i_data_x`.
- `o_core_data_x_prev`  out  NB_DATA  accumulator to `ghash_core.i_data_x_prev`.
- `o_core_valid`  out  1  to `ghash_core.i_valid`.
- `i_core_data_y`  in  NB_DATA  from `ghash_core.o_data_y`.
- `o_ghash`  out  NB_DATA  final GHASH; held until the next result.
- `o_ghash_valid`  out  1  one-cycle pulse.
- `o_busy`  out  1  high in every state except IDLE.
- `o_error`  out  1  sticky ordering error (see Configuration).

## Operation
- States: IDLE, ACCEPT, WAIT, LEN, WAIT_LEN.
- **IDLE**
  - `o_ready=0`.
  - `i_start` → ACCEPT, or → LEN if `i_start_empty`.
- **ACCEPT**
  - `o_ready=1`.
  - On handshake, register `o_core_data_x = i_data` with bytes ≥ `i_nbytes` zeroed.
  - Register `o_core_data_x_prev = acc` and `o_core_valid=1`.
  - Add `8*nbytes` to `len_a` (if `i_is_aad`) or to `len_c`.
  - Latch `i_last`, load the wait counter with `CORE_LATENCY`, → WAIT.
- **WAIT**
  - `o_ready=0`.
  - Counter decrements each cycle; at zero, `acc <= i_core_data_y`.
  - → LEN if the latched last flag is set, else → ACCEPT.
- **LEN**
  - Register `o_core_data_x = {len_a[63:0], len_c[63:0]}`, `o_core_data_x_prev = acc`, `o_core_valid=1`.
  - → WAIT_LEN.
- **WAIT_LEN**
  - Same countdown as WAIT; at zero, `o_ghash <= i_core_data_y`, `o_ghash_valid=1`, → IDLE.
- Length counters are 64-bit bit counts and wrap modulo 2^64.
- `i_start` in any non-IDLE state aborts the message.
  - acc, lengths and counter are cleared; the in-flight core result is discarded.
  - Next state is ACCEPT, or LEN if `i_start_empty`.
- `i_start` coincident with a handshake in ACCEPT: the start wins and the block is not accepted.
- `i_valid` outside ACCEPT is ignored.
- `i_last` on an AAD-only message is legal; `len_c` stays 0.

## Timing
- Reset values: all outputs 0, state IDLE, acc 0, `len_a`/`len_c` 0.
- Handshake accepted at edge t:
  - `o_core_valid` is high for exactly the cycle after t.
  - `i_core_data_y` is sampled `CORE_LATENCY` edges later.
  - `o_ready` is high again on the following cycle.
- Throughput: one block per `CORE_LATENCY+2` cycles.
- `o_ghash_valid` asserts `CORE_LATENCY+1` cycles after `o_core_valid` of the length block.
- `o_core_data_x` and `o_core_data_x_prev` hold their values while `o_core_valid` is low.
- Asynchronous reset mid-message: immediate return to IDLE with all reset values and no `o_ghash_valid`.

## Configuration
- `GHASH_SEQ_ORDER_CHECK_EN`
  - Defined: an AAD block accepted after any ciphertext block in the same message sets `o_error`. The block is still processed. `o_error` clears only on `i_start` or `i_reset`.
  - Undefined: no ordering check; `o_error` is tied to 0.

## Test plan
- **Empty message:** H=`66e94bd4ef8a2c3b884cfa59ca342b2e`, `i_start` + `i_start_empty` → core sees x=0, x_prev=0; `o_ghash=0`, a single `o_ghash_valid` pulse.
- **One full ciphertext block:** `0388dace60b6a392f328c2b971b2fe78`, same H, `i_nbytes`=16, `i_last` → length block `{64'd0, 64'h80}`; `o_ghash=f38cbb1ad69223dcc3457ae5b6b0f885`.
- **Partial AAD block:** `i_data` all-ones, `i_nbytes`=4 → `o_core_data_x=ffffffff` followed by 96 zero bits; length block `{64'h20, 64'd0}`.
- **Latency sweep:** `CORE_LATENCY`=1 and 4 with a 3-block message → `o_ready` gaps of 2 and 5 cycles; `o_ghash` identical to the latency-1 result.
- **Abort:** `i_start` during WAIT of block 2 → result discarded, `len_a`/`len_c` restart from 0, and a subsequent one-block message gives the same value as from reset. Also, an async `i_reset` in WAIT_LEN → no valid pulse, all outputs 0.
- **Ordering** (macro defined): ciphertext block followed by an AAD block → `o_error=1`, held until the next `i_start`. Macro undefined → `o_error` stays 0.
